// File: rtl/i8088_bus_ctrl.sv
// 8088 local-bus sequencer: synchronises the pin strobes, latches the address on ALE,
// sends one request per bus cycle to an internal target, and holds READY low until that cycle is done.
module i8088_bus_ctrl #(
  parameter logic [19:0] BRAM_TOP = 20'h20000,
  parameter logic [19:0] ROM_BASE = 20'hF0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ale,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic        io_nm,
  input  logic [11:0] a19_8,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [1:0]  req_tgt,
  output logic [19:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  output logic        err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [23:0] SYNC_RST = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00};

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STROBE, S_REQ, S_RSP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [23:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic          ale_prev_q, ale_prev_d;
  logic [19:0]   addr_q, addr_d;
  logic          io_q, io_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d, ad_oe_q, ad_oe_d;
  logic [7:0]    ad_out_q, ad_out_d;
  logic          req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [1:0]    req_tgt_q, req_tgt_d;
  logic [19:0]   req_addr_q, req_addr_d;
  logic [7:0]    req_wdata_q, req_wdata_d;
  logic          err_q, err_d;

  logic        ale_s, n_rd_s, n_wr_s, io_nm_s, timeout_hit;
  logic [11:0] a19_8_s;
  logic [7:0]  ad_in_s;

  // All pins share one pipeline so address and strobes stay cycle-aligned.
  always_comb begin
    sync1_d = {ale, n_rd, n_wr, io_nm, a19_8, ad_in};
    sync2_d = sync1_q;
    {ale_s, n_rd_s, n_wr_s, io_nm_s, a19_8_s, ad_in_s} = sync2_q;
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    ale_prev_d  = ale_s;
    addr_d      = addr_q;
    io_d        = io_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    ad_oe_d     = ad_oe_q;
    ad_out_d    = ad_out_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_tgt_d   = req_tgt_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        ad_oe_d = 1'b0;
        if (ale_s) begin
          addr_d = {a19_8_s, ad_in_s};
          io_d   = io_nm_s;
        end
        if (ale_prev_q && !ale_s) begin
          state_d = S_ADDR;
          ready_d = 1'b0;
        end
      end
      S_ADDR: begin
        if (io_q) begin
          req_tgt_d  = 2'd3;
          req_addr_d = {4'h0, addr_q[15:0]};
        end else begin
          req_addr_d = addr_q;
          if (addr_q < BRAM_TOP)       req_tgt_d = 2'd0;
          else if (addr_q >= ROM_BASE) req_tgt_d = 2'd2;
          else                         req_tgt_d = 2'd1;
        end
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (!n_wr_s) begin
          req_wdata_d = ad_in_s;
          req_we_d    = 1'b1;
          req_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_REQ;
        end else if (!n_rd_s) begin
          req_we_d    = 1'b0;
          req_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_REQ;
        end else if (ale_s && !ale_prev_q) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REQ, S_RSP: begin
        cnt_d = cnt_q + CW'(1);
        // A completion on the timeout cycle takes priority over the timeout.
        if (state_q == S_REQ && req_ready) begin
          req_valid_d = 1'b0;
          if (req_we_q) begin
            ready_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RSP;
          end
        end else if (state_q == S_RSP && rsp_valid) begin
          ad_out_d = rsp_rdata;
          ready_d  = 1'b1;
          ad_oe_d  = !n_rd_s;
          state_d  = S_DONE;
        end else if (timeout_hit) begin
          req_valid_d = 1'b0;
          ad_out_d    = 8'hFF;
          err_d       = 1'b1;
          ready_d     = 1'b1;
          ad_oe_d     = !req_we_q && !n_rd_s;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        ad_oe_d = !req_we_q && !n_rd_s;
        if (n_rd_s && n_wr_s) begin
          ad_oe_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      ale_prev_q  <= 1'b0;
      addr_q      <= '0;
      io_q        <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_tgt_q   <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      ale_prev_q  <= ale_prev_d;
      addr_q      <= addr_d;
      io_q        <= io_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_tgt_q   <= req_tgt_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      err_q       <= err_d;
    end
  end

  assign ready       = ready_q;
  assign ad_oe       = ad_oe_q;
  assign ad_out      = ad_out_q;
  assign req_valid   = req_valid_q;
  assign req_we      = req_we_q;
  assign req_tgt     = req_tgt_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_i8088_bus_ctrl.sv
// Directed bench for i8088_bus_ctrl: drives 8088 pin sequences and plays a simple target,
// then compares outputs against hand-computed values.
module tb_i8088_bus_ctrl;

  localparam int unsigned TO = 1024;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ale = 1'b0, n_rd = 1'b1, n_wr = 1'b1, io_nm = 1'b0;
  logic [11:0] a19_8 = '0;
  logic [7:0]  ad_in = '0;
  logic [7:0]  ad_out;
  logic        ad_oe, ready, req_valid, req_we, err_timeout;
  logic        req_ready = 1'b1;
  logic [1:0]  req_tgt;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = '0;

  int checks = 0;
  int errors = 0;

  i8088_bus_ctrl #(.BRAM_TOP(20'h20000), .ROM_BASE(20'hF0000), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .ale(ale), .n_rd(n_rd), .n_wr(n_wr), .io_nm(io_nm),
    .a19_8(a19_8), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ready(ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_tgt(req_tgt),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cycle(input logic io, input logic [19:0] addr, input logic we,
                             input logic [7:0] wd);
    ale   = 1'b1;
    io_nm = io;
    a19_8 = addr[19:8];
    ad_in = addr[7:0];
    tick(2);
    ale = 1'b0;
    tick(1);
    if (we) begin
      ad_in = wd;
      n_wr  = 1'b0;
    end else begin
      n_rd = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (req_valid) break;
      tick(1);
    end
    check({tag, "_valid"}, {31'b0, req_valid}, 32'd1);
  endtask

  task automatic finish_cycle(input string tag);
    n_rd = 1'b1;
    n_wr = 1'b1;
    tick(4);
    check({tag, "_oe_off"}, {31'b0, ad_oe}, 32'd0);
    check({tag, "_idle_rdy"}, {31'b0, ready}, 32'd1);
  endtask

  // Full bus cycle: optional backpressure, then read response after lat cycles.
  task automatic do_cycle(input string tag, input logic io, input logic [19:0] addr,
                          input logic we, input logic [7:0] wd, input logic [1:0] exp_tgt,
                          input logic [19:0] exp_addr, input int bp, input int lat,
                          input logic [7:0] rd);
    req_ready = (bp == 0);
    start_cycle(io, addr, we, wd);
    wait_valid(tag);
    check({tag, "_tgt"}, {30'b0, req_tgt}, {30'b0, exp_tgt});
    check({tag, "_addr"}, {12'b0, req_addr}, {12'b0, exp_addr});
    check({tag, "_we"}, {31'b0, req_we}, {31'b0, we});
    if (we) check({tag, "_wdata"}, {24'b0, req_wdata}, {24'b0, wd});
    for (int i = 0; i < bp; i++) begin
      check({tag, "_bp_hold"}, {req_valid, ready, req_we, req_tgt, req_wdata, req_addr},
            {1'b1, 1'b0, we, exp_tgt, (we ? wd : req_wdata), exp_addr});
      tick(1);
    end
    req_ready = 1'b1;
    check({tag, "_pre_rdy"}, {31'b0, ready}, 32'd0);
    tick(1);
    check({tag, "_valid_drop"}, {31'b0, req_valid}, 32'd0);
    if (we) begin
      check({tag, "_wr_rdy"}, {31'b0, ready}, 32'd1);
    end else begin
      tick(lat);
      check({tag, "_rsp_wait"}, {31'b0, ready}, 32'd0);
      rsp_valid = 1'b1;
      rsp_rdata = rd;
      tick(1);
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      check({tag, "_rd_rdy"}, {30'b0, ready, ad_oe}, 32'd3);
      check({tag, "_rdata"}, {24'b0, ad_out}, {24'b0, rd});
    end
    finish_cycle(tag);
  endtask

  initial begin
    int n;
    logic seen;

    for (int i = 0; i < 128; i++) begin
      tick(1);
      check("rst_hold", {29'b0, ready, req_valid, ad_oe}, 32'd0);
    end
    check("rst_vals", {ad_out, req_we, req_tgt, req_wdata, err_timeout}, '0);
    check("rst_addr", {12'b0, req_addr}, '0);
    resetn = 1'b1;
    check("rst_rel_rdy0", {31'b0, ready}, 32'd0);
    tick(1);
    check("rst_rel_rdy1", {31'b0, ready}, 32'd1);
    tick(3);

    do_cycle("io_wr", 1'b1, 20'h00009, 1'b1, 8'h06, 2'd3, 20'h00009, 0, 0, 8'h00);
    do_cycle("ddr_rd", 1'b0, 20'h20000, 1'b0, 8'h00, 2'd1, 20'h20000, 0, 10, 8'h5A);
    do_cycle("b_1ffff", 1'b0, 20'h1FFFF, 1'b0, 8'h00, 2'd0, 20'h1FFFF, 0, 0, 8'h11);
    do_cycle("b_effff", 1'b0, 20'hEFFFF, 1'b0, 8'h00, 2'd1, 20'hEFFFF, 0, 2, 8'h22);
    do_cycle("b_f0000", 1'b0, 20'hF0000, 1'b0, 8'h00, 2'd2, 20'hF0000, 0, 1, 8'h33);
    do_cycle("b_ffff0", 1'b0, 20'hFFFF0, 1'b0, 8'h00, 2'd2, 20'hFFFF0, 0, 0, 8'h44);
    do_cycle("io_rd81", 1'b1, 20'h00081, 1'b0, 8'h00, 2'd3, 20'h00081, 0, 3, 8'h3C);
    do_cycle("io_hi", 1'b1, 20'h5ABCD, 1'b1, 8'h77, 2'd3, 20'h0ABCD, 0, 0, 8'h00);
    do_cycle("bp_wr", 1'b0, 20'h01234, 1'b1, 8'hA5, 2'd0, 20'h01234, 5, 0, 8'h00);
    do_cycle("bp_rd", 1'b0, 20'h80000, 1'b0, 8'h00, 2'd1, 20'h80000, 5, 4, 8'hC3);
    check("no_err_yet", {31'b0, err_timeout}, 32'd0);

    // Aborted cycle: ALE rises again with no strobe.
    ale = 1'b1; a19_8 = 12'h123; ad_in = 8'h45; io_nm = 1'b0;
    tick(2);
    ale = 1'b0;
    tick(5);
    check("abort_rdy0", {31'b0, ready}, 32'd0);
    seen = 1'b0;
    ale = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen = seen | req_valid;
    end
    check("abort_novalid", {31'b0, seen}, 32'd0);
    check("abort_rdy1", {31'b0, ready}, 32'd1);

    // Timeout: read with no response.
    req_ready = 1'b1;
    start_cycle(1'b0, 20'hFFFF0, 1'b0, 8'h00);
    wait_valid("to");
    tick(1);
    n = 0;
    while (!ready && n < int'(TO) + 50) begin
      tick(1);
      n++;
    end
    check("to_ready", {31'b0, ready}, 32'd1);
    check("to_lat_ok", {31'b0, (n >= int'(TO) - 8 && n <= int'(TO) + 8)}, 32'd1);
    check("to_adout", {24'b0, ad_out}, 32'h000000FF);
    check("to_err", {31'b0, err_timeout}, 32'd1);
    check("to_oe", {31'b0, ad_oe}, 32'd1);
    finish_cycle("to");

    do_cycle("post_to", 1'b0, 20'h00100, 1'b1, 8'h9E, 2'd0, 20'h00100, 0, 0, 8'h00);
    check("err_sticky", {31'b0, err_timeout}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i8088_bus_ctrl.md
# i8088_bus_ctrl

Sequencer between the raw 8088 local-bus pins and the FPGA's internal memory and IO targets (BRAM, DDR, boot ROM, IO peripherals such as the UART and the GPIO latch). It synchronises the asynchronous bus strobes and captures the multiplexed address on ALE. It decodes the cycle to a target, issues one request per bus cycle and holds READY low until the target completes. On reads it also drives the returned data onto AD7..0.

## Interface
Parameters:
- `BRAM_TOP`, 20'h20000: memory addresses below this go to BRAM.
- `ROM_BASE`, 20'hF0000: memory addresses at or above this go to boot ROM. The range `BRAM_TOP`..`ROM_BASE-1` goes to DDR.
- `TIMEOUT`, 1024: cycles allowed for a target response before forced completion.

Ports:
- Clock and reset: one clock, `clk`; reset `resetn` is synchronous and active-low.
- `clk`  in  1  system clock (100 MHz).
- `resetn`  in  1  synchronous active-low reset.
- `ale`, `n_rd`, `n_wr`, `io_nm`  in  1 each  raw 8088 strobes (asynchronous).
- `a19_8`  in  12  raw upper address pins.
- `ad_in`  in  8  raw AD7..0 input.
- `ad_out`  out  8  read data to AD7..0.
- `ad_oe`  out  1  AD7..0 output enable.
- `ready`  out  1  8088 READY.
- `req_valid`  out  1  request to target.
- `req_ready`  in  1  target accepts request.
- `req_we`  out  1  1 = write.
- `req_tgt`  out  2  target select: 0 BRAM, 1 DDR, 2 ROM, 3 IO.
- `req_addr`  out  20  byte address; for IO, bits 19:16 are zero.
- `req_wdata`  out  8  write data.
- `rsp_valid`  in  1  read data valid (single-cycle pulse).
- `rsp_rdata`  in  8  read data.
- `err_timeout`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Synchronisation: `ale`, `n_rd`, `n_wr`, `io_nm`, `a19_8` and `ad_in` all pass through an identical 2-flop pipeline, so address and strobes stay aligned. In the rest of this spec, `*_s` denotes the synchronised signals.
- States: IDLE, ADDR, STROBE, REQ, RSP, DONE.
- IDLE:
  - `ready`=1, `ad_oe`=0.
  - While `ale_s`=1, capture {`a19_8_s`, `ad_in_s`} and `io_nm_s` every cycle.
  - On `ale_s` falling edge: go to ADDR and drive `ready`=0.
- ADDR: decode the captured address into `req_tgt`.
  - If `io_nm`=1, target is IO.
  - Otherwise compare against `BRAM_TOP` and `ROM_BASE`.
  - Go to STROBE.
- STROBE:
  - `n_wr_s`=0: latch `ad_in_s` into `req_wdata`, set `req_we`=1, go to REQ.
  - `n_rd_s`=0: set `req_we`=0, go to REQ.
  - `ale_s` rises again with no strobe seen (aborted cycle): return to IDLE with no request issued.
- REQ:
  - Assert `req_valid` and hold all `req_*` stable until `req_ready`=1.
  - On a write, accept completes the cycle: go to DONE.
  - On a read, accept goes to RSP.
- RSP: wait for `rsp_valid`, then latch `rsp_rdata` into `ad_out` and go to DONE.
- Timeout: one cycle counter runs from REQ entry through RSP.
  - When it reaches `TIMEOUT`, drop `req_valid`, set `ad_out`=8'hFF, set `err_timeout`=1 and go to DONE.
  - A `req_ready` or `rsp_valid` arriving on the same cycle as the timeout wins; the timeout is not flagged.
- DONE:
  - `ready`=1.
  - `ad_oe`=1 only for reads and only while `n_rd_s`=0.
  - When both `n_rd_s` and `n_wr_s` are high, go to IDLE. `ad_oe` drops that same cycle.
- An `ale_s` edge outside IDLE/STROBE is ignored: each bus cycle runs to completion.
- Reset while a cycle is in progress: immediate return to IDLE, all outputs go to reset values, and any outstanding request is dropped. Targets must tolerate `req_valid` falling before accept.

## Timing
- Reset values:
  - `ready`=0, `ad_oe`=0, `ad_out`=0.
  - `req_valid`=0, `req_we`=0, `req_tgt`=0, `req_addr`=0, `req_wdata`=0.
  - `err_timeout`=0.
- `ready` rises 1 cycle after `resetn` deasserts (IDLE).
- Raw pin to `*_s`: 2 cycles.
- `ale_s` falling edge → `ready`=0: 1 cycle.
- `ale_s` falling edge → earliest `req_valid`: 3 cycles (ADDR, then STROBE sees strobe, then REQ).
- Write completion: `req_valid` & `req_ready` → `ready`=1 on the next cycle.
- Read completion: `rsp_valid` → `ready`=1 and `ad_oe`=1 on the next cycle.
- `rsp_valid` is ignored outside RSP.
- Throughput: one bus cycle outstanding at a time. Minimum IDLE→IDLE round trip is 5 cycles plus target latency.

## Test plan
- Reset: hold `resetn`=0 for 128 cycles → `ready`=0, `req_valid`=0, `ad_oe`=0 throughout; `ready`=1 exactly 1 cycle after release.
- IO write to 0x0009 with data 0x06:
  - Required request: `req_tgt`=3, `req_addr`=20'h00009, `req_we`=1, `req_wdata`=0x06.
  - With `req_ready` tied high, `ready` rises 1 cycle after accept.
- Memory read at 0x20000, `rsp_valid` returned 10 cycles after accept with 0x5A:
  - Required request: `req_tgt`=1 (DDR).
  - `ready` rises one cycle after the response.
  - `ad_oe`=1 with `ad_out`=0x5A while `n_rd` is low; `ad_oe`=0 after `n_rd` rises.
- Decode boundaries:
  - 0x1FFFF → BRAM.
  - 0xEFFFF → DDR.
  - 0xF0000 and 0xFFFF0 → ROM.
  - IO address 0x0081 → `req_tgt`=3, `req_addr`=0x00081.
- Backpressure: `req_ready`=0 for 5 cycles → `req_valid` and all `req_*` fields stable for those 5 cycles; `ready` stays 0.
- Timeout: read at 0xFFFF0 with no response → after `TIMEOUT` cycles, `ready`=1, `ad_out`=0xFF, `err_timeout`=1. `err_timeout` remains 1 through a following successful cycle.
